comp_result_tracker: RTL and testbench
======================================

COMP_RESULT_TRACKER -- requirements
Module: comp_result_tracker

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of each outcome/error counter.
REQ-002 SHALL have parameter RUN_LEN, default 4, number of consecutive equal results that raises eq_run_hit; legal range 2..255.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port in_valid  input  1  comparator result present this cycle.
REQ-006 SHALL have port in_y1, in_y2, in_y3  input  1 each  comparator flags: a<b, a==b, a>b.
REQ-007 SHALL have port clr  input  1  synchronous clear of counters and run tracker.
REQ-008 SHALL have port lt_cnt, eq_cnt, gt_cnt, err_cnt  output  CNT_W each  live saturating counts.
REQ-009 SHALL have port last_res  output  2  last legal result: 00 none, 01 LT, 10 EQ, 11 GT.
REQ-010 SHALL have port onehot_err  output  1  one-cycle pulse for an illegal flag pattern.
REQ-011 SHALL have port eq_run_hit  output  1  one-cycle pulse when the equal-run reaches RUN_LEN.
REQ-012 SHALL have port snap_req  input  1  request a counter snapshot.
REQ-013 SHALL have port snap_valid  output  1  snapshot held on snap_lt/snap_eq/snap_gt/snap_err.
REQ-014 SHALL have port snap_ready  input  1  consumer accepts snapshot.
REQ-015 SHALL have port snap_lt, snap_eq, snap_gt, snap_err  output  CNT_W each  frozen counter copies.

Function
REQ-016 A sample SHALL be accepted on any edge with in_valid=1 and clr=0; its effects SHALL be visible on outputs the following cycle (latency 1).
REQ-017 A legal sample (exactly one flag set) SHALL increment the matching counter and update last_res.
REQ-018 An illegal sample (zero, two or three flags set) SHALL increment err_cnt, pulse onehot_err for one cycle, reset the equal-run, and leave lt/eq/gt counters and last_res unchanged.
REQ-019 All counters SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-020 Equal-run: a legal EQ sample SHALL increment the run (saturating at RUN_LEN); a legal LT/GT or illegal sample SHALL reset it to 0; cycles with in_valid=0 SHALL leave it unchanged.
REQ-021 eq_run_hit SHALL pulse only on the cycle after the run transitions from RUN_LEN-1 to RUN_LEN; further EQ samples SHALL not re-pulse until the run is reset.
REQ-022 clr SHALL zero all four counters, the run and last_res on the next edge; clr with in_valid=1 SHALL discard the sample (no pulses).
REQ-023 Snapshot FSM SHALL have states IDLE (snap_valid=0) and HOLD (snap_valid=1).
REQ-024 IDLE with snap_req=1 SHALL copy the counter values present before that edge (excluding any same-edge sample) into snap_* and enter HOLD.
REQ-025 HOLD SHALL keep snap_* stable and ignore snap_req; snap_ready=1 SHALL return to IDLE; a request must be re-asserted after return.
REQ-026 clr SHALL not affect the snapshot FSM or snap_* registers; counting SHALL continue while in HOLD.

Reset
REQ-027 rst_n low SHALL asynchronously force all counters, snap_* , run, last_res to 0, onehot_err and eq_run_hit to 0, and the FSM to IDLE, including mid-snapshot.
REQ-028 Release SHALL be synchronised to clk; first sample SHALL be accepted no earlier than the first edge after rst_n high.

Structure
REQ-029 Package comp_pkg SHALL hold the result encoding enum (NONE/LT/EQ/GT), the snapshot state enum, and default CNT_W/RUN_LEN constants.
REQ-030 A sub-module sat_counter (parameter width, inputs inc/clr, output count) SHALL implement each of the four counters.

Verification
REQ-031 Reset, then LT,EQ,GT one each -> lt=eq=gt=1, err=0, last_res=11 one cycle after the GT sample.
REQ-032 Flags 110, then 000 -> err_cnt=2, two onehot_err pulses, lt/eq/gt=0, last_res=00.
REQ-033 EQ x4 with in_valid gaps between -> single eq_run_hit after fourth; EQ x2 more -> no pulse; GT then EQ x4 -> second pulse.
REQ-034 CNT_W=4, 17 LT samples -> lt_cnt holds 15.
REQ-035 eq_cnt=5, snap_req with EQ sample same edge -> snap_eq=5, eq_cnt=6; snap_ready low 10 cycles -> snap_* stable; snap_ready high -> snap_valid 0 next cycle.
REQ-036 rst_n low mid-HOLD and clr with in_valid same cycle -> all outputs 0 / sample discarded, FSM IDLE.

Source files
------------

// File: rtl/comp_pkg.sv
// ----------------------------------------------------------------------------
// comp_pkg
// Shared types and defaults for the comparator result tracker.
//   res_t        : encoding of the last legal comparator result
//   snap_state_t : snapshot handshake states
//   DEF_CNT_W    : default counter width
//   DEF_RUN_LEN  : default equal-run length that raises eq_run_hit
//   RUN_W        : width of the equal-run register (covers RUN_LEN up to 255)
//   is_onehot3() : true when exactly one of the three comparator flags is set
// ----------------------------------------------------------------------------
package comp_pkg;

   localparam int DEF_CNT_W   = 16;
   localparam int DEF_RUN_LEN = 4;
   localparam int RUN_W       = 8;

   typedef enum logic [1:0] {
      RES_NONE = 2'b00,
      RES_LT   = 2'b01,
      RES_EQ   = 2'b10,
      RES_GT   = 2'b11
   } res_t;

   typedef enum logic {
      SNAP_IDLE = 1'b0,
      SNAP_HOLD = 1'b1
   } snap_state_t;

   function automatic logic is_onehot3(input logic [2:0] flags);
      return (flags == 3'b001) || (flags == 3'b010) || (flags == 3'b100);
   endfunction

endpackage

// File: rtl/comp_result_tracker_if.sv
// ----------------------------------------------------------------------------
// comp_result_tracker_if
// Groups the comparator sample bus and the snapshot handshake.
//   in_valid, in_y1/in_y2/in_y3 : comparator sample (a<b, a==b, a>b)
//   snap_req, snap_ready        : snapshot request / consumer accept
//   snap_valid, snap_*          : held snapshot of the four counters
// master = sample producer / snapshot consumer, slave = the tracker.
// ----------------------------------------------------------------------------
interface comp_result_tracker_if import comp_pkg::*; #(
   parameter int CNT_W = DEF_CNT_W
);

   logic             in_valid;
   logic             in_y1;
   logic             in_y2;
   logic             in_y3;
   logic             snap_req;
   logic             snap_ready;
   logic             snap_valid;
   logic [CNT_W-1:0] snap_lt;
   logic [CNT_W-1:0] snap_eq;
   logic [CNT_W-1:0] snap_gt;
   logic [CNT_W-1:0] snap_err;

   modport master (
      output in_valid, in_y1, in_y2, in_y3, snap_req, snap_ready,
      input  snap_valid, snap_lt, snap_eq, snap_gt, snap_err
   );

   modport slave (
      input  in_valid, in_y1, in_y2, in_y3, snap_req, snap_ready,
      output snap_valid, snap_lt, snap_eq, snap_gt, snap_err
   );

endinterface

// File: rtl/sat_counter.sv
// ----------------------------------------------------------------------------
// sat_counter
// Up-counter that sticks at its all-ones value instead of wrapping.
//   clk, rst_n : clock, asynchronous active-low reset
//   inc        : count one event this cycle
//   clr        : synchronous clear (wins over inc)
//   count      : current value
// ----------------------------------------------------------------------------
module sat_counter #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             inc,
   input  logic             clr,
   output logic [WIDTH-1:0] count
);

   // Clear has priority; once all ones the counter holds its value.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (inc && (count != '1)) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/comp_result_tracker.sv
// ----------------------------------------------------------------------------
// comp_result_tracker
// Tallies comparator results, flags illegal flag patterns, detects runs of
// equal results and offers a frozen snapshot of the counters on request.
//   clk, rst_n           : clock, asynchronous active-low reset
//   clr                  : synchronous clear of counters, run and last_res
//   bus (slave)          : sample input and snapshot handshake
//   lt/eq/gt/err_cnt     : live saturating counters
//   last_res             : last legal result (00 none, 01 LT, 10 EQ, 11 GT)
//   onehot_err           : one-cycle pulse after an illegal sample
//   eq_run_hit           : one-cycle pulse when the equal-run reaches RUN_LEN
// ----------------------------------------------------------------------------
module comp_result_tracker import comp_pkg::*; #(
   parameter int CNT_W   = DEF_CNT_W,
   parameter int RUN_LEN = DEF_RUN_LEN
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  clr,
   comp_result_tracker_if.slave  bus,
   output logic [CNT_W-1:0]      lt_cnt,
   output logic [CNT_W-1:0]      eq_cnt,
   output logic [CNT_W-1:0]      gt_cnt,
   output logic [CNT_W-1:0]      err_cnt,
   output logic [1:0]            last_res,
   output logic                  onehot_err,
   output logic                  eq_run_hit
);

   localparam logic [RUN_W-1:0] RUN_TOP  = RUN_W'(RUN_LEN);
   localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(RUN_LEN - 1);

   logic [1:0]       rst_pipe;
   logic             rst_sync_n;
   logic [2:0]       flags;
   logic             legal;
   logic             accept;
   logic             take_lt;
   logic             take_eq;
   logic             take_gt;
   logic             take_err;
   res_t             last_q;
   logic [RUN_W-1:0] run;
   snap_state_t      snap_state;

   // Reset asserts immediately but releases only after two clock edges, so
   // every downstream flop leaves reset on the same clean edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rst_pipe <= 2'b00;
      end else begin
         rst_pipe <= {rst_pipe[0], 1'b1};
      end
   end

   assign rst_sync_n = rst_pipe[1];

   // Classify the incoming sample; a clear on the same edge discards it.
   assign flags    = {bus.in_y3, bus.in_y2, bus.in_y1};
   assign legal    = is_onehot3(flags);
   assign accept   = bus.in_valid && !clr;
   assign take_lt  = accept && legal && bus.in_y1;
   assign take_eq  = accept && legal && bus.in_y2;
   assign take_gt  = accept && legal && bus.in_y3;
   assign take_err = accept && !legal;

   sat_counter #(.WIDTH(CNT_W)) u_lt_cnt (
      .clk(clk), .rst_n(rst_sync_n), .inc(take_lt), .clr(clr), .count(lt_cnt)
   );
   sat_counter #(.WIDTH(CNT_W)) u_eq_cnt (
      .clk(clk), .rst_n(rst_sync_n), .inc(take_eq), .clr(clr), .count(eq_cnt)
   );
   sat_counter #(.WIDTH(CNT_W)) u_gt_cnt (
      .clk(clk), .rst_n(rst_sync_n), .inc(take_gt), .clr(clr), .count(gt_cnt)
   );
   sat_counter #(.WIDTH(CNT_W)) u_err_cnt (
      .clk(clk), .rst_n(rst_sync_n), .inc(take_err), .clr(clr), .count(err_cnt)
   );

   // Last legal result, equal-run length and the two status pulses. The run
   // parks at RUN_LEN, so the hit pulse fires only on the step into RUN_LEN.
   always_ff @(posedge clk or negedge rst_sync_n) begin
      if (!rst_sync_n) begin
         last_q     <= RES_NONE;
         run        <= '0;
         onehot_err <= 1'b0;
         eq_run_hit <= 1'b0;
      end else begin
         onehot_err <= take_err;
         eq_run_hit <= take_eq && (run == RUN_LAST);
         if (clr) begin
            last_q <= RES_NONE;
            run    <= '0;
         end else if (accept) begin
            if (!legal) begin
               run <= '0;
            end else if (take_eq) begin
               last_q <= RES_EQ;
               if (run != RUN_TOP) begin
                  run <= run + 1'b1;
               end
            end else begin
               last_q <= take_lt ? RES_LT : RES_GT;
               run    <= '0;
            end
         end
      end
   end

   assign last_res = last_q;

   // Snapshot handshake: capture the pre-edge counter values on a request,
   // hold them until the consumer accepts. clr leaves this untouched.
   always_ff @(posedge clk or negedge rst_sync_n) begin
      if (!rst_sync_n) begin
         snap_state     <= SNAP_IDLE;
         bus.snap_valid <= 1'b0;
         bus.snap_lt    <= '0;
         bus.snap_eq    <= '0;
         bus.snap_gt    <= '0;
         bus.snap_err   <= '0;
      end else begin
         case (snap_state)
            SNAP_IDLE: begin
               if (bus.snap_req) begin
                  bus.snap_lt    <= lt_cnt;
                  bus.snap_eq    <= eq_cnt;
                  bus.snap_gt    <= gt_cnt;
                  bus.snap_err   <= err_cnt;
                  bus.snap_valid <= 1'b1;
                  snap_state     <= SNAP_HOLD;
               end
            end
            SNAP_HOLD: begin
               if (bus.snap_ready) begin
                  bus.snap_valid <= 1'b0;
                  snap_state     <= SNAP_IDLE;
               end
            end
            default: begin
               bus.snap_valid <= 1'b0;
               snap_state     <= SNAP_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_comp_result_tracker.sv
// ----------------------------------------------------------------------------
// tb_comp_result_tracker
// Directed scenarios followed by randomized traffic, each cycle compared
// against a behavioural model of the counting, run and snapshot rules.
// ----------------------------------------------------------------------------
module tb_comp_result_tracker;

   localparam int CNT_W   = 4;
   localparam int RUN_LEN = 4;
   localparam int MAXC    = (1 << CNT_W) - 1;

   localparam bit [2:0] F_LT = 3'b001;
   localparam bit [2:0] F_EQ = 3'b010;
   localparam bit [2:0] F_GT = 3'b100;

   logic             clk   = 1'b0;
   logic             rst_n = 1'b0;
   logic             clr   = 1'b0;
   logic [CNT_W-1:0] lt_cnt;
   logic [CNT_W-1:0] eq_cnt;
   logic [CNT_W-1:0] gt_cnt;
   logic [CNT_W-1:0] err_cnt;
   logic [1:0]       last_res;
   logic             onehot_err;
   logic             eq_run_hit;

   comp_result_tracker_if #(.CNT_W(CNT_W)) bus ();

   comp_result_tracker #(.CNT_W(CNT_W), .RUN_LEN(RUN_LEN)) dut (
      .clk(clk), .rst_n(rst_n), .clr(clr), .bus(bus),
      .lt_cnt(lt_cnt), .eq_cnt(eq_cnt), .gt_cnt(gt_cnt), .err_cnt(err_cnt),
      .last_res(last_res), .onehot_err(onehot_err), .eq_run_hit(eq_run_hit)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int errors   = 0;
   int hit_seen = 0;

   // Behavioural model state
   int m_lt, m_eq, m_gt, m_err, m_run, m_last;
   int m_slt, m_seq, m_sgt, m_serr;
   bit m_oh, m_hit, m_hold;

   function automatic int sat(input int v);
      return (v > MAXC) ? MAXC : v;
   endfunction

   task automatic model_reset();
      m_lt = 0; m_eq = 0; m_gt = 0; m_err = 0; m_run = 0; m_last = 0;
      m_slt = 0; m_seq = 0; m_sgt = 0; m_serr = 0;
      m_oh = 1'b0; m_hit = 1'b0; m_hold = 1'b0;
   endtask

   // Apply one clock edge of the specification's rules to the model.
   task automatic model_edge(input bit vld, input bit [2:0] f, input bit c,
                             input bit sreq, input bit srdy);
      int n;
      if (!m_hold && sreq) begin
         m_slt = m_lt; m_seq = m_eq; m_sgt = m_gt; m_serr = m_err;
         m_hold = 1'b1;
      end else if (m_hold && srdy) begin
         m_hold = 1'b0;
      end
      m_oh  = 1'b0;
      m_hit = 1'b0;
      if (c) begin
         m_lt = 0; m_eq = 0; m_gt = 0; m_err = 0; m_run = 0; m_last = 0;
      end else if (vld) begin
         n = int'(f[0]) + int'(f[1]) + int'(f[2]);
         if (n != 1) begin
            m_err = sat(m_err + 1); m_oh = 1'b1; m_run = 0;
         end else if (f[0]) begin
            m_lt = sat(m_lt + 1); m_last = 1; m_run = 0;
         end else if (f[1]) begin
            m_eq = sat(m_eq + 1); m_last = 2;
            if (m_run == RUN_LEN - 1) m_hit = 1'b1;
            if (m_run < RUN_LEN) m_run = m_run + 1;
         end else begin
            m_gt = sat(m_gt + 1); m_last = 3; m_run = 0;
         end
      end
   endtask

   task automatic check_output(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s observed %0d expected %0d", tag, observed, expected);
      end
   endtask

   task automatic check_all();
      check_output("lt_cnt", 32'(lt_cnt), m_lt);
      check_output("eq_cnt", 32'(eq_cnt), m_eq);
      check_output("gt_cnt", 32'(gt_cnt), m_gt);
      check_output("err_cnt", 32'(err_cnt), m_err);
      check_output("last_res", 32'(last_res), m_last);
      check_output("onehot_err", 32'(onehot_err), 32'(m_oh));
      check_output("eq_run_hit", 32'(eq_run_hit), 32'(m_hit));
      check_output("snap_valid", 32'(bus.snap_valid), 32'(m_hold));
      check_output("snap_lt", 32'(bus.snap_lt), m_slt);
      check_output("snap_eq", 32'(bus.snap_eq), m_seq);
      check_output("snap_gt", 32'(bus.snap_gt), m_sgt);
      check_output("snap_err", 32'(bus.snap_err), m_serr);
   endtask

   // Drive one cycle of inputs at the falling edge, update the model at the
   // rising edge and compare shortly after it.
   task automatic apply_stimulus(input bit vld, input bit [2:0] f, input bit c,
                                 input bit sreq, input bit srdy);
      @(negedge clk);
      bus.in_valid   = vld;
      bus.in_y1      = f[0];
      bus.in_y2      = f[1];
      bus.in_y3      = f[2];
      clr            = c;
      bus.snap_req   = sreq;
      bus.snap_ready = srdy;
      @(posedge clk);
      model_edge(vld, f, c, sreq, srdy);
      #1;
      check_all();
      if (eq_run_hit === 1'b1) hit_seen++;
   endtask

   task automatic release_reset();
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) apply_stimulus(1'b0, 3'b000, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      int hits_before;
      bit [2:0] f;
      bus.in_valid = 1'b0; bus.in_y1 = 1'b0; bus.in_y2 = 1'b0; bus.in_y3 = 1'b0;
      bus.snap_req = 1'b0; bus.snap_ready = 1'b0;
      model_reset();

      // Reset state
      repeat (2) apply_stimulus(1'b0, 3'b000, 1'b0, 1'b0, 1'b0);
      release_reset();

      // One of each legal result
      apply_stimulus(1'b1, F_LT, 1'b0, 1'b0, 1'b0);
      apply_stimulus(1'b1, F_EQ, 1'b0, 1'b0, 1'b0);
      apply_stimulus(1'b1, F_GT, 1'b0, 1'b0, 1'b0);
      check_output("basic_lt", 32'(lt_cnt), 1);
      check_output("basic_eq", 32'(eq_cnt), 1);
      check_output("basic_gt", 32'(gt_cnt), 1);
      check_output("basic_last", 32'(last_res), 3);

      // Illegal patterns: two flags, then none
      apply_stimulus(1'b0, 3'b000, 1'b1, 1'b0, 1'b0);
      apply_stimulus(1'b1, 3'b011, 1'b0, 1'b0, 1'b0);
      check_output("illegal_pulse1", 32'(onehot_err), 1);
      apply_stimulus(1'b1, 3'b000, 1'b0, 1'b0, 1'b0);
      check_output("illegal_pulse2", 32'(onehot_err), 1);
      check_output("illegal_err", 32'(err_cnt), 2);
      check_output("illegal_last", 32'(last_res), 0);

      // Equal runs with valid gaps
      apply_stimulus(1'b0, 3'b000, 1'b1, 1'b0, 1'b0);
      hits_before = hit_seen;
      for (int i = 0; i < 4; i++) begin
         apply_stimulus(1'b1, F_EQ, 1'b0, 1'b0, 1'b0);
         if (i < 3) apply_stimulus(1'b0, F_EQ, 1'b0, 1'b0, 1'b0);
      end
      check_output("run_hit_first", 32'(eq_run_hit), 1);
      apply_stimulus(1'b0, 3'b000, 1'b0, 1'b0, 1'b0);
      apply_stimulus(1'b1, F_EQ, 1'b0, 1'b0, 1'b0);
      apply_stimulus(1'b1, F_EQ, 1'b0, 1'b0, 1'b0);
      check_output("run_no_repulse", 32'(eq_run_hit), 0);
      apply_stimulus(1'b1, F_GT, 1'b0, 1'b0, 1'b0);
      repeat (4) apply_stimulus(1'b1, F_EQ, 1'b0, 1'b0, 1'b0);
      check_output("run_hit_second", 32'(eq_run_hit), 1);
      check_output("run_hit_total", hit_seen - hits_before, 2);

      // Saturation
      apply_stimulus(1'b0, 3'b000, 1'b1, 1'b0, 1'b0);
      repeat (17) apply_stimulus(1'b1, F_LT, 1'b0, 1'b0, 1'b0);
      check_output("sat_lt", 32'(lt_cnt), MAXC);

      // Snapshot with a same-edge sample, then a long hold
      apply_stimulus(1'b0, 3'b000, 1'b1, 1'b0, 1'b0);
      repeat (5) apply_stimulus(1'b1, F_EQ, 1'b0, 1'b0, 1'b0);
      apply_stimulus(1'b1, F_EQ, 1'b0, 1'b1, 1'b0);
      check_output("snap_eq_pre", 32'(bus.snap_eq), 5);
      check_output("snap_eq_live", 32'(eq_cnt), 6);
      for (int i = 0; i < 10; i++) begin
         apply_stimulus(1'b1, 3'($urandom_range(0, 7)), (i == 5), 1'($urandom), 1'b0);
         check_output("snap_hold_eq", 32'(bus.snap_eq), 5);
      end
      apply_stimulus(1'b0, 3'b000, 1'b0, 1'b0, 1'b1);
      check_output("snap_release", 32'(bus.snap_valid), 0);

      // Reset in the middle of a hold
      apply_stimulus(1'b1, F_GT, 1'b0, 1'b1, 1'b0);
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      check_all();
      apply_stimulus(1'b0, 3'b000, 1'b0, 1'b0, 1'b0);
      release_reset();

      // Clear together with a sample discards it
      apply_stimulus(1'b1, F_EQ, 1'b0, 1'b0, 1'b0);
      apply_stimulus(1'b1, F_EQ, 1'b1, 1'b0, 1'b0);
      check_output("clr_discard_eq", 32'(eq_cnt), 0);
      apply_stimulus(1'b1, 3'b011, 1'b1, 1'b0, 1'b0);
      check_output("clr_discard_err", 32'(onehot_err), 0);

      // Randomized traffic
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 3) == 0) f = 3'($urandom_range(0, 7));
         else f = 3'b001 << $urandom_range(0, 2);
         apply_stimulus($urandom_range(0, 3) != 0, f, $urandom_range(0, 19) == 0,
                        $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
